// File: rtl/nco_pkg.sv
// nco_pkg: shared definitions for the NCO command scheduler.
//   - Opcode encodings carried in command bits [31:28]
//   - Command word field positions (opcode, voice, payload)
//   - Scheduler FSM state encoding
//   - Waveform select encoding written to the NCO bank
package nco_pkg;

  localparam logic [3:0] OP_NOP         = 4'h0;
  localparam logic [3:0] OP_STAGE_FREQ  = 4'h1;
  localparam logic [3:0] OP_STAGE_WAVE  = 4'h2;
  localparam logic [3:0] OP_COMMIT      = 4'h3;
  localparam logic [3:0] OP_PHASE_RESET = 4'h4;

  localparam int OPC_MSB     = 31;
  localparam int OPC_LSB     = 28;
  localparam int VOICE_MSB   = 27;
  localparam int VOICE_LSB   = 24;
  localparam int PAYLOAD_MSB = 23;
  localparam int PAYLOAD_LSB = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    WAVE_SINE     = 2'd0,
    WAVE_SAW      = 2'd1,
    WAVE_SQUARE   = 2'd2,
    WAVE_TRIANGLE = 2'd3
  } wave_e;

endpackage

// File: rtl/nco_cmd_fifo.sv
// nco_cmd_fifo: synchronous FIFO for SPI-fed command words.
// Ports:
//   i_clock, i_reset  clock, synchronous active-high reset
//   i_push, i_data    write strobe and word (caller guarantees push is legal,
//                     i.e. not full, or full with a pop in the same cycle)
//   i_pop             read strobe (caller guarantees not empty)
//   o_data            head-of-queue word (valid while !o_empty)
//   o_full, o_empty   occupancy flags
//   o_count           number of stored words (0..DEPTH)
module nco_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = i_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = i_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({i_push, i_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; contents are only observed behind count_q.
  always_ff @(posedge i_clock) begin
    if (i_push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;

endmodule

// File: rtl/nco_cmd_scheduler.sv
// nco_cmd_scheduler: buffers SPI command words, stages per-voice frequency and
// waveform in shadow registers, and on COMMIT writes every dirty voice to the
// single-port NCO bank, one voice per accepted write.
// Optional feature macro: NCO_SCHED_ERR_EN adds o_cmd_error / o_err_opcode.
// Ports:
//   i_clock, i_reset      clock, synchronous active-high reset
//   i_cmd_valid, i_cmd    command strobe and word ([31:28] op, [27:24] voice)
//   o_cmd_overflow        sticky: a command was dropped on a full FIFO
//   o_busy                FIFO non-empty or FSM not IDLE
//   o_bank_wr_en, i_bank_ready, o_bank_addr, o_bank_freq, o_bank_wave
//                         bank write port. Handshake: a write completes on the
//                         cycle where o_bank_wr_en and i_bank_ready are both
//                         high; address/data stay stable until then.
//   o_phase_rst           one-hot, one-cycle phase-reset pulse
//   o_dbg_state           current FSM state
//   o_cmd_error, o_err_opcode (NCO_SCHED_ERR_EN only) sticky illegal-command
//                         flag and opcode of the first illegal command
module nco_cmd_scheduler
  import nco_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int FREQ_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  input  logic [31:0]           i_cmd,
  output logic                  o_cmd_overflow,
  output logic                  o_busy,
  output logic                  o_bank_wr_en,
  input  logic                  i_bank_ready,
  output logic [3:0]            o_bank_addr,
  output logic [FREQ_W-1:0]     o_bank_freq,
  output logic [1:0]            o_bank_wave,
  output logic [NUM_VOICES-1:0] o_phase_rst,
  output state_e                o_dbg_state
`ifdef NCO_SCHED_ERR_EN
  ,
  output logic                  o_cmd_error,
  output logic [3:0]            o_err_opcode
`endif
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_VOICES - 1);
  localparam logic [4:0]       NUM_VOICES_W = 5'(NUM_VOICES);

  state_e                  state_q, state_d;
  logic [31:0]             cmd_q, cmd_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [FREQ_W-1:0]       freq_q [NUM_VOICES];
  logic [FREQ_W-1:0]       freq_d [NUM_VOICES];
  wave_e                   wave_q [NUM_VOICES];
  wave_e                   wave_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]   dirty_q, dirty_d;
  logic                    ovf_q, ovf_d;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic [31:0]             fifo_head;

  // Pop only from IDLE; a simultaneous pop frees a slot for a push when full.
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
  assign fifo_push = i_cmd_valid && (!fifo_full || fifo_pop);

  nco_cmd_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_push  (fifo_push),
    .i_data  (i_cmd),
    .i_pop   (fifo_pop),
    .o_data  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // Decode of the command currently held for EXEC.
  logic [3:0]       cmd_op, cmd_voice;
  logic [IDX_W-1:0] voice_idx;
  logic             voice_ok, cmd_illegal;

  assign cmd_op    = cmd_q[OPC_MSB:OPC_LSB];
  assign cmd_voice = cmd_q[VOICE_MSB:VOICE_LSB];
  assign voice_idx = cmd_q[VOICE_LSB +: IDX_W];
  assign voice_ok  = ({1'b0, cmd_voice} < NUM_VOICES_W);
  // Voice range only matters for opcodes that address a voice.
  assign cmd_illegal = (cmd_op > OP_PHASE_RESET) ||
                       (((cmd_op == OP_STAGE_FREQ) || (cmd_op == OP_STAGE_WAVE) ||
                         (cmd_op == OP_PHASE_RESET)) && !voice_ok);

`ifdef NCO_SCHED_ERR_EN
  logic       err_q, err_d;
  logic [3:0] err_op_q, err_op_d;
`endif

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    idx_d        = idx_q;
    freq_d       = freq_q;
    wave_d       = wave_q;
    dirty_d      = dirty_q;
    ovf_d        = ovf_q | (i_cmd_valid & ~fifo_push);
    o_bank_wr_en = 1'b0;
    o_bank_addr  = '0;
    o_bank_freq  = '0;
    o_bank_wave  = '0;
    o_phase_rst  = '0;
`ifdef NCO_SCHED_ERR_EN
    err_d        = err_q;
    err_op_d     = err_op_q;
`endif
    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          cmd_d   = fifo_head;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = IDLE;
        if (!cmd_illegal) begin
          case (cmd_op)
            OP_STAGE_FREQ: begin
              freq_d[voice_idx]  = cmd_q[PAYLOAD_LSB +: FREQ_W];
              dirty_d[voice_idx] = 1'b1;
            end
            OP_STAGE_WAVE: begin
              wave_d[voice_idx]  = wave_e'(cmd_q[PAYLOAD_LSB +: 2]);
              dirty_d[voice_idx] = 1'b1;
            end
            OP_COMMIT: begin
              idx_d   = '0;
              state_d = COMMIT;
            end
            OP_PHASE_RESET: o_phase_rst[voice_idx] = 1'b1;
            default: ;
          endcase
        end
`ifdef NCO_SCHED_ERR_EN
        else if (!err_q) begin
          err_d    = 1'b1;
          err_op_d = cmd_op;
        end
`endif
      end
      COMMIT: begin
        o_bank_wr_en = dirty_q[idx_q];
        o_bank_addr  = 4'(idx_q);
        o_bank_freq  = freq_q[idx_q];
        o_bank_wave  = wave_q[idx_q];
        // Clean voices are skipped in one cycle; dirty ones wait for ready.
        if (!dirty_q[idx_q] || i_bank_ready) begin
          dirty_d[idx_q] = 1'b0;
          if (idx_q == LAST_IDX) state_d = IDLE;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      idx_q   <= '0;
      freq_q  <= '{default: '0};
      wave_q  <= '{default: WAVE_SINE};
      dirty_q <= '0;
      ovf_q   <= 1'b0;
`ifdef NCO_SCHED_ERR_EN
      err_q    <= 1'b0;
      err_op_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      freq_q  <= freq_d;
      wave_q  <= wave_d;
      dirty_q <= dirty_d;
      ovf_q   <= ovf_d;
`ifdef NCO_SCHED_ERR_EN
      err_q    <= err_d;
      err_op_q <= err_op_d;
`endif
    end
  end

  assign o_cmd_overflow = ovf_q;
  assign o_busy         = (fifo_count != '0) || (state_q != IDLE);
  assign o_dbg_state    = state_q;
`ifdef NCO_SCHED_ERR_EN
  assign o_cmd_error    = err_q;
  assign o_err_opcode   = err_op_q;
`endif

endmodule

// File: tb/tb_nco_cmd_scheduler.sv
// tb_nco_cmd_scheduler: directed self-checking bench for nco_cmd_scheduler
// (NUM_VOICES=8, FREQ_W=24, FIFO_DEPTH=4). Error-reporting checks are
// compiled in when NCO_SCHED_ERR_EN is defined.
module tb_nco_cmd_scheduler;
  import nco_pkg::*;

  logic        i_clock;
  logic        i_reset;
  logic        i_cmd_valid;
  logic [31:0] i_cmd;
  logic        o_cmd_overflow;
  logic        o_busy;
  logic        o_bank_wr_en;
  logic        i_bank_ready;
  logic [3:0]  o_bank_addr;
  logic [23:0] o_bank_freq;
  logic [1:0]  o_bank_wave;
  logic [7:0]  o_phase_rst;
  state_e      o_dbg_state;
`ifdef NCO_SCHED_ERR_EN
  logic        o_cmd_error;
  logic [3:0]  o_err_opcode;
`endif

  nco_cmd_scheduler #(.NUM_VOICES(8), .FREQ_W(24), .FIFO_DEPTH(4)) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_cmd_valid    (i_cmd_valid),
    .i_cmd          (i_cmd),
    .o_cmd_overflow (o_cmd_overflow),
    .o_busy         (o_busy),
    .o_bank_wr_en   (o_bank_wr_en),
    .i_bank_ready   (i_bank_ready),
    .o_bank_addr    (o_bank_addr),
    .o_bank_freq    (o_bank_freq),
    .o_bank_wave    (o_bank_wave),
    .o_phase_rst    (o_phase_rst),
    .o_dbg_state    (o_dbg_state)
`ifdef NCO_SCHED_ERR_EN
    ,
    .o_cmd_error    (o_cmd_error),
    .o_err_opcode   (o_err_opcode)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected TB_RESULT before 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  int checks   = 0;
  int failures = 0;

  // Commit monitor results.
  int          commit_cycles;
  int          wr_count;
  bit          commit_done;
  bit          stall_ok;
  logic [3:0]  wr_addr [8];
  logic [23:0] wr_freq [8];
  logic [1:0]  wr_wave [8];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic push_cmd(input logic [31:0] c);
    i_cmd       = c;
    i_cmd_valid = 1'b1;
    tick();
    i_cmd_valid = 1'b0;
    i_cmd       = '0;
  endtask

  // Waits for a COMMIT to start and run to completion, recording every
  // accepted write. The first stall_n cycles with a write pending are held off
  // with i_bank_ready low, and the presented write must not change meanwhile.
  task automatic monitor_commit(input int stall_n, input int budget);
    bit          seen, check_release;
    int          stalls_left;
    logic [3:0]  h_addr;
    logic [23:0] h_freq;
    logic [1:0]  h_wave;
    seen          = 1'b0;
    check_release = 1'b0;
    stalls_left   = stall_n;
    commit_cycles = 0;
    wr_count      = 0;
    commit_done   = 1'b0;
    stall_ok      = 1'b1;
    h_addr = '0; h_freq = '0; h_wave = '0;
    i_bank_ready  = 1'b1;
    for (int c = 0; c < budget; c++) begin
      if (o_dbg_state == COMMIT) begin
        seen = 1'b1;
        commit_cycles++;
        if (o_bank_wr_en && stalls_left > 0) begin
          i_bank_ready = 1'b0;
          if (stalls_left == stall_n) begin
            h_addr = o_bank_addr; h_freq = o_bank_freq; h_wave = o_bank_wave;
          end else if (o_bank_addr !== h_addr || o_bank_freq !== h_freq ||
                       o_bank_wave !== h_wave) begin
            stall_ok = 1'b0;
          end
          stalls_left--;
          check_release = 1'b1;
        end else begin
          i_bank_ready = 1'b1;
          if (o_bank_wr_en) begin
            if (check_release) begin
              if (o_bank_addr !== h_addr || o_bank_freq !== h_freq ||
                  o_bank_wave !== h_wave) stall_ok = 1'b0;
              check_release = 1'b0;
            end
            if (wr_count < 8) begin
              wr_addr[wr_count] = o_bank_addr;
              wr_freq[wr_count] = o_bank_freq;
              wr_wave[wr_count] = o_bank_wave;
            end
            wr_count++;
          end
        end
      end else if (seen) begin
        commit_done = 1'b1;
        break;
      end
      tick();
    end
    i_bank_ready = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({o_bank_wr_en, o_bank_addr, o_bank_freq, o_bank_wave, o_phase_rst,
         o_cmd_overflow, o_busy} !== 41'd0) begin
      failures++;
      $display("FAIL reset_outputs: got wr=%b addr=%h freq=%h wave=%h ph=%h ovf=%b busy=%b expected all 0",
               o_bank_wr_en, o_bank_addr, o_bank_freq, o_bank_wave, o_phase_rst, o_cmd_overflow, o_busy);
    end
    checks++;
    if (o_dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d expected %0d", o_dbg_state, IDLE);
    end
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_phase_reset();
    push_cmd(32'h4300_0000);
    checks++;
    if (o_phase_rst !== 8'h00 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL phase_early: got ph=%h busy=%b expected ph=00 busy=1", o_phase_rst, o_busy);
    end
    tick();
    checks++;
    if (o_phase_rst !== 8'b0000_1000) begin
      failures++;
      $display("FAIL phase_pulse: got %b expected 00001000", o_phase_rst);
    end
    tick();
    checks++;
    if (o_phase_rst !== 8'h00) begin
      failures++;
      $display("FAIL phase_width: got %b expected 00000000", o_phase_rst);
    end
  endtask

  task automatic test_stage_commit();
    i_bank_ready = 1'b1;
    push_cmd(32'h1200_1234);
    push_cmd(32'h2200_0003);
    push_cmd(32'h3000_0000);
    monitor_commit(0, 60);
    checks++;
    if (commit_done !== 1'b1 || commit_cycles != 8) begin
      failures++;
      $display("FAIL stage_commit_len: got done=%b cycles=%0d expected done=1 cycles=8", commit_done, commit_cycles);
    end
    checks++;
    if (wr_count != 1) begin
      failures++;
      $display("FAIL stage_wr_count: got %0d expected 1", wr_count);
    end else begin
      checks++;
      if (wr_addr[0] !== 4'h2 || wr_freq[0] !== 24'h001234 || wr_wave[0] !== 2'd3) begin
        failures++;
        $display("FAIL stage_wr_data: got addr=%h freq=%h wave=%h expected addr=2 freq=001234 wave=3",
                 wr_addr[0], wr_freq[0], wr_wave[0]);
      end
    end
    // A second commit right away must find every dirty bit cleared.
    push_cmd(32'h3000_0000);
    monitor_commit(0, 60);
    checks++;
    if (commit_done !== 1'b1 || commit_cycles != 8 || wr_count != 0) begin
      failures++;
      $display("FAIL clean_commit: got done=%b cycles=%0d writes=%0d expected done=1 cycles=8 writes=0",
               commit_done, commit_cycles, wr_count);
    end
  endtask

  task automatic test_backpressure();
    push_cmd(32'h1000_0AAA);
    push_cmd(32'h2500_0001);
    push_cmd(32'h3000_0000);
    monitor_commit(3, 80);
    checks++;
    if (commit_done !== 1'b1 || commit_cycles != 11) begin
      failures++;
      $display("FAIL bp_commit_len: got done=%b cycles=%0d expected done=1 cycles=11", commit_done, commit_cycles);
    end
    checks++;
    if (stall_ok !== 1'b1) begin
      failures++;
      $display("FAIL bp_stable: got changed expected stable outputs during stall");
    end
    checks++;
    if (wr_count != 2) begin
      failures++;
      $display("FAIL bp_wr_count: got %0d expected 2", wr_count);
    end else begin
      checks++;
      if (wr_addr[0] !== 4'h0 || wr_freq[0] !== 24'h000AAA || wr_wave[0] !== 2'd0) begin
        failures++;
        $display("FAIL bp_wr0: got addr=%h freq=%h wave=%h expected addr=0 freq=000aaa wave=0",
                 wr_addr[0], wr_freq[0], wr_wave[0]);
      end
      checks++;
      if (wr_addr[1] !== 4'h5 || wr_freq[1] !== 24'h000000 || wr_wave[1] !== 2'd1) begin
        failures++;
        $display("FAIL bp_wr1: got addr=%h freq=%h wave=%h expected addr=5 freq=000000 wave=1",
                 wr_addr[1], wr_freq[1], wr_wave[1]);
      end
    end
  endtask

  task automatic test_overflow();
    bit reached;
    int pulse_cnt, other_cnt;
    logic [31:0] burst [5];
    burst[0] = 32'h1300_0333;
    burst[1] = 32'h2300_0002;
    burst[2] = 32'h4600_0000;
    burst[3] = 32'h1300_0999;
    burst[4] = 32'h1400_0444;
    push_cmd(32'h1100_0111);
    push_cmd(32'h3000_0000);
    i_bank_ready = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (o_dbg_state == COMMIT && o_bank_wr_en) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (reached !== 1'b1) begin
      failures++;
      $display("FAIL ovf_stall_reached: got 0 expected 1");
    end
    for (int k = 0; k < 4; k++) push_cmd(burst[k]);
    checks++;
    if (o_cmd_overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_early: got %b expected 0", o_cmd_overflow);
    end
    push_cmd(burst[4]);
    checks++;
    if (o_cmd_overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: got %b expected 1", o_cmd_overflow);
    end
    monitor_commit(0, 40);
    checks++;
    if (commit_done !== 1'b1 || wr_count != 1 || wr_addr[0] !== 4'h1 || wr_freq[0] !== 24'h000111) begin
      failures++;
      $display("FAIL ovf_first_commit: got done=%b writes=%0d addr=%h freq=%h expected done=1 writes=1 addr=1 freq=000111",
               commit_done, wr_count, wr_addr[0], wr_freq[0]);
    end
    pulse_cnt = 0;
    other_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_phase_rst == 8'h40) pulse_cnt++;
      else if (o_phase_rst != 8'h00) other_cnt++;
      tick();
    end
    checks++;
    if (pulse_cnt != 1 || other_cnt != 0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL ovf_drain: got pulses=%0d stray=%0d busy=%b expected pulses=1 stray=0 busy=0",
               pulse_cnt, other_cnt, o_busy);
    end
    push_cmd(32'h3000_0000);
    monitor_commit(0, 60);
    checks++;
    if (commit_done !== 1'b1 || wr_count != 1) begin
      failures++;
      $display("FAIL ovf_second_commit: got done=%b writes=%0d expected done=1 writes=1", commit_done, wr_count);
    end else begin
      checks++;
      if (wr_addr[0] !== 4'h3 || wr_freq[0] !== 24'h000999 || wr_wave[0] !== 2'd2) begin
        failures++;
        $display("FAIL ovf_order: got addr=%h freq=%h wave=%h expected addr=3 freq=000999 wave=2",
                 wr_addr[0], wr_freq[0], wr_wave[0]);
      end
    end
    checks++;
    if (o_cmd_overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky: got %b expected 1", o_cmd_overflow);
    end
  endtask

  task automatic test_reset_mid_commit();
    bit reached;
    i_bank_ready = 1'b1;
    push_cmd(32'h1200_0050);
    push_cmd(32'h2600_0003);
    push_cmd(32'h3000_0000);
    reached = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (o_dbg_state == COMMIT) begin
        reached = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (reached !== 1'b1) begin
      failures++;
      $display("FAIL rst_commit_reached: got 0 expected 1");
    end
    tick();
    tick();
    i_reset = 1'b1;
    tick();
    checks++;
    if ({o_bank_wr_en, o_bank_addr, o_bank_freq, o_bank_wave, o_phase_rst,
         o_cmd_overflow, o_busy} !== 41'd0 || o_dbg_state !== IDLE) begin
      failures++;
      $display("FAIL rst_mid_commit: got wr=%b addr=%h ovf=%b busy=%b state=%0d expected all 0 and IDLE",
               o_bank_wr_en, o_bank_addr, o_cmd_overflow, o_busy, o_dbg_state);
    end
    i_reset = 1'b0;
    tick();
    push_cmd(32'h3000_0000);
    monitor_commit(0, 60);
    checks++;
    if (commit_done !== 1'b1 || commit_cycles != 8 || wr_count != 0) begin
      failures++;
      $display("FAIL rst_after_commit: got done=%b cycles=%0d writes=%0d expected done=1 cycles=8 writes=0",
               commit_done, commit_cycles, wr_count);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] ph_seen;
    ph_seen = '0;
    push_cmd(32'h1900_0001);
    push_cmd(32'h7000_0000);
    push_cmd(32'h4900_0000);
    push_cmd(32'h2F00_0002);
    for (int c = 0; c < 12; c++) begin
      ph_seen = ph_seen | o_phase_rst;
      tick();
    end
    checks++;
    if (ph_seen !== 8'h00 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL illegal_phase: got ph=%h busy=%b expected ph=00 busy=0", ph_seen, o_busy);
    end
`ifdef NCO_SCHED_ERR_EN
    checks++;
    if (o_cmd_error !== 1'b1 || o_err_opcode !== 4'h1) begin
      failures++;
      $display("FAIL illegal_err_flag: got err=%b op=%h expected err=1 op=1", o_cmd_error, o_err_opcode);
    end
`endif
    push_cmd(32'h3000_0000);
    monitor_commit(0, 60);
    checks++;
    if (commit_done !== 1'b1 || commit_cycles != 8 || wr_count != 0) begin
      failures++;
      $display("FAIL illegal_no_effect: got done=%b cycles=%0d writes=%0d expected done=1 cycles=8 writes=0",
               commit_done, commit_cycles, wr_count);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    i_reset      = 1'b1;
    i_cmd_valid  = 1'b0;
    i_cmd        = '0;
    i_bank_ready = 1'b0;
    test_reset();
    test_phase_reset();
    test_stage_commit();
    test_backpressure();
    test_overflow();
    test_reset_mid_commit();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
